// File: rtl/pkt_buffer_pkg.sv
// pkt_buffer_pkg: shared write-FSM state type and buffer entry sizing for pkt_buffer.
package pkt_buffer_pkg;
  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;
  localparam int FLAG_W = 2;
  function automatic int entry_w(input int dwidth);
    return dwidth + FLAG_W;
  endfunction
endpackage

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram: one write port, one read port with registered output, no reset.
module simple_dual_port_ram #(
  parameter int AW = 9,
  parameter int W  = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pkt_buffer.sv
// pkt_buffer: store-and-forward Avalon-ST packet buffer; packets that are too long
// or do not fit are dropped instead of back-pressuring the sink.
module pkt_buffer
  import pkt_buffer_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 256,
  parameter int DEPTH       = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DWIDTH-1:0]      snk_data_i,
  input  logic                   snk_startofpacket_i,
  input  logic                   snk_endofpacket_i,
  input  logic                   snk_valid_i,
  output logic                   snk_ready_o,
  output logic [DWIDTH-1:0]      src_data_o,
  output logic                   src_startofpacket_o,
  output logic                   src_endofpacket_o,
  output logic                   src_valid_o,
  input  logic                   src_ready_i,
  output logic                   drop_o,
  output logic [$clog2(DEPTH):0] pkt_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = entry_w(DWIDTH);
  localparam int LW = $clog2(MAX_PKT_LEN + 1);

  wr_state_t     state;
  logic [PW-1:0] wr_ptr, com_ptr, pkt_start, rd_ptr, out_ptr, base;
  logic [LW-1:0] len;
  logic [EW-1:0] rdata;
  logic          acc, full, start, cont, we, commit, drop_now;
  logic          avail, xfer, move, re, ram_vld;

  // Fullness is judged against words not yet handed downstream, so the output stage counts as occupied.
  always_comb begin
    acc      = snk_valid_i && snk_ready_o;
    base     = (state == WR_PKT && snk_startofpacket_i) ? pkt_start : wr_ptr;
    full     = (base ^ out_ptr) == {1'b1, {AW{1'b0}}};
    start    = acc && snk_startofpacket_i && !full;
    cont     = acc && !snk_startofpacket_i && state == WR_PKT && !full && len != LW'(MAX_PKT_LEN);
    we       = start || cont;
    commit   = we && snk_endofpacket_i;
    drop_now = acc && (state == WR_PKT ? (snk_startofpacket_i || !cont) : (snk_startofpacket_i && full));
    avail    = rd_ptr != com_ptr;
    xfer     = src_valid_o && src_ready_i;
    move     = ram_vld && (!src_valid_o || src_ready_i);
    re       = avail && (!ram_vld || move);
  end

  simple_dual_port_ram #(.AW(AW), .W(EW)) u_ram (
    .clk  (clk_i),
    .we   (we),
    .waddr(base[AW-1:0]),
    .wdata({snk_startofpacket_i, snk_endofpacket_i, snk_data_i}),
    .re   (re),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= WR_IDLE;
      wr_ptr      <= '0;
      com_ptr     <= '0;
      pkt_start   <= '0;
      len         <= '0;
      pkt_cnt_o   <= '0;
      drop_o      <= 1'b0;
      snk_ready_o <= 1'b0;
    end else begin
      snk_ready_o <= 1'b1;
      drop_o      <= drop_now;
      if (we) wr_ptr <= base + 1'b1;
      else if (drop_now && state == WR_PKT) wr_ptr <= pkt_start;
      if (start) pkt_start <= base;
      len <= start ? LW'(1) : cont ? len + 1'b1 : len;
      if (commit) com_ptr <= base + 1'b1;
      pkt_cnt_o <= pkt_cnt_o + PW'(commit) - PW'(xfer && src_endofpacket_o);
      if (acc) state <= we ? (snk_endofpacket_i ? WR_IDLE : WR_PKT)
                           : snk_endofpacket_i ? WR_IDLE : drop_now ? WR_DROP : state;
    end
  end

  // RAM output acts as a second pipeline slot; it is only refetched once it can drain into src.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr              <= '0;
      out_ptr             <= '0;
      ram_vld             <= 1'b0;
      src_valid_o         <= 1'b0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_data_o          <= '0;
    end else begin
      if (re) rd_ptr <= rd_ptr + 1'b1;
      if (xfer) out_ptr <= out_ptr + 1'b1;
      ram_vld <= re || (ram_vld && !move);
      if (move) {src_startofpacket_o, src_endofpacket_o, src_data_o} <= rdata;
      src_valid_o <= move || (src_valid_o && !src_ready_i);
    end
  end
endmodule

// File: tb/tb_pkt_buffer.sv
// tb_pkt_buffer: directed and randomized stimulus for pkt_buffer, checked against a
// packet-level model (committed-word queue plus the packet currently being received).
module tb_pkt_buffer;
  localparam int DW = 8, MAXL = 256, DEPTH = 512, CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] snk_data = '0;
  logic          snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0, snk_ready;
  logic [DW-1:0] src_data;
  logic          src_sop, src_eop, src_valid, src_ready = 1'b0, drop;
  logic [CW-1:0] pkt_cnt;

  int            checks = 0, errors = 0;
  logic [DW+1:0] exp_q[$], cur_q[$], got_q[$];
  logic [DW+1:0] w;
  bit            in_pkt = 0, drop_pend = 0, rnd_ready = 0;
  int            delivered = 0, drops = 0, idle = 0, eops = 0;
  int            d0, dr0, kind;

  always #5 clk = ~clk;

  pkt_buffer dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .snk_data_i         (snk_data),
    .snk_startofpacket_i(snk_sop),
    .snk_endofpacket_i  (snk_eop),
    .snk_valid_i        (snk_valid),
    .snk_ready_o        (snk_ready),
    .src_data_o         (src_data),
    .src_startofpacket_o(src_sop),
    .src_endofpacket_o  (src_eop),
    .src_valid_o        (src_valid),
    .src_ready_i        (src_ready),
    .drop_o             (drop),
    .pkt_cnt_o          (pkt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor at negedge: outputs reflect the last posedge, inputs are what the next posedge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {src_valid, src_sop, src_eop, src_data, snk_ready, drop, pkt_cnt}, 32'd0);
      exp_q.delete();
      cur_q.delete();
      in_pkt = 0;
      drop_pend = 0;
      idle = 0;
    end else begin
      eops = 0;
      foreach (exp_q[i]) eops += int'(exp_q[i][DW]);
      chk("pkt_cnt", pkt_cnt, eops);
      chk("drop_pulse", drop, drop_pend);
      if (drop) drops++;
      if (src_valid) begin
        if (exp_q.size() == 0) chk("src_spurious", src_valid, 1'b0);
        else chk("src_word", {src_sop, src_eop, src_data}, exp_q[0]);
      end
      idle = (exp_q.size() > 0 && !src_valid) ? idle + 1 : 0;
      if (idle > 0) chk("first_word_latency", idle <= 3, 1'b1);
      drop_pend = 0;
      if (snk_valid) begin
        chk("snk_ready", snk_ready, 1'b1);
        w = {snk_sop, snk_eop, snk_data};
        if (snk_sop) begin
          drop_pend = in_pkt;
          cur_q.delete();
          in_pkt = 0;
          if (exp_q.size() >= DEPTH) drop_pend = 1;
          else begin
            cur_q.push_back(w);
            in_pkt = 1;
          end
        end else if (in_pkt) begin
          if (cur_q.size() >= MAXL || exp_q.size() + cur_q.size() >= DEPTH) begin
            drop_pend = 1;
            cur_q.delete();
            in_pkt = 0;
          end else cur_q.push_back(w);
        end
        if (in_pkt && snk_eop) begin
          foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
          cur_q.delete();
          in_pkt = 0;
        end
      end
      if (src_valid && src_ready) begin
        got_q.push_back({src_sop, src_eop, src_data});
        delivered++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) src_ready = $urandom_range(3) != 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e);
    snk_valid = 1'b1;
    snk_data  = d;
    snk_sop   = s;
    snk_eop   = e;
    step();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int gap_pct, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) step();
      send(DW'($urandom), i == 0, with_eop && i == n - 1);
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() > 0 || src_valid) && n < limit) begin
      step();
      n++;
    end
    chk("drain_timeout", n < limit, 1'b1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();

    // Basic 4-word packet, store-and-forward and count 0 -> 1 -> 0.
    src_ready = 1'b1;
    got_q.delete();
    send(8'h11, 1, 0);
    send(8'h22, 0, 0);
    send(8'h33, 0, 0);
    chk("store_and_forward", src_valid, 1'b0);
    send(8'h44, 0, 1);
    chk("cnt_after_commit", pkt_cnt, 1);
    drain(20);
    chk("basic_len", got_q.size(), 4);
    chk("basic_first", got_q[0], {2'b10, 8'h11});
    chk("basic_second", got_q[1], {2'b00, 8'h22});
    chk("basic_last", got_q[3], {2'b01, 8'h44});
    chk("basic_cnt_end", pkt_cnt, 0);

    // Over-long packet dropped, following packet intact.
    d0 = delivered;
    dr0 = drops;
    send_pkt(MAXL + 1, 0, 1);
    step();
    chk("long_drop", drops - dr0, 1);
    chk("long_cnt", pkt_cnt, 0);
    chk("long_nothing_out", delivered - d0, 0);
    send_pkt(2, 0, 1);
    drain(20);
    chk("after_long", delivered - d0, 2);

    // Fill the buffer with the output stalled: third packet overflows.
    src_ready = 1'b0;
    d0 = delivered;
    dr0 = drops;
    repeat (3) send_pkt(200, 0, 1);
    step();
    chk("fill_cnt", pkt_cnt, 2);
    chk("fill_drop", drops - dr0, 1);
    src_ready = 1'b1;
    drain(1000);
    chk("fill_out", delivered - d0, 400);

    // New sop inside an open packet.
    d0 = delivered;
    dr0 = drops;
    send(8'h5a, 1, 0);
    send(8'h5b, 0, 0);
    send_pkt(4, 0, 1);
    step();
    drain(30);
    chk("sop_drop", drops - dr0, 1);
    chk("sop_deliver", delivered - d0, 4);

    // Single-word packet committed in the same cycle a prior eop is transferred.
    src_ready = 1'b0;
    got_q.delete();
    send_pkt(2, 0, 1);
    repeat (4) step();
    chk("pre_coincide_cnt", pkt_cnt, 1);
    src_ready = 1'b1;
    step();
    send(8'hA5, 1, 1);
    chk("coincide_cnt", pkt_cnt, 1);
    drain(20);
    chk("single_len", got_q.size(), 3);
    chk("single_word", got_q[2], {2'b11, 8'hA5});

    // Randomized traffic: gaps, stray words, truncated packets, random src_ready.
    d0 = delivered;
    rnd_ready = 1;
    for (int p = 0; p < 80; p++) begin
      kind = $urandom_range(9);
      if (kind == 0) send(DW'($urandom), 0, 1'($urandom_range(1)));
      else if (kind == 1) send_pkt($urandom_range(1, 5), 20, 0);
      else send_pkt($urandom_range(1, 24), 30, 1);
    end
    rnd_ready = 0;
    src_ready = 1'b1;
    drain(3000);
    chk("random_delivered_some", delivered > d0, 1'b1);

    // Reset mid-packet with two packets stored.
    src_ready = 1'b0;
    send_pkt(3, 0, 1);
    send_pkt(5, 0, 1);
    send_pkt(4, 0, 0);
    chk("pre_reset_cnt", pkt_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("reset_valid", src_valid, 1'b0);
    chk("reset_cnt", pkt_cnt, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    d0 = delivered;
    src_ready = 1'b1;
    send_pkt(6, 0, 1);
    drain(30);
    chk("post_reset_deliver", delivered - d0, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
